// File: rtl/sistema_pkg.sv
// Shared types and constants for the sequential 4-bit calculator: FSM states,
// enable patterns, operation codes and the 7-segment decoder.
package sistema_pkg;

  typedef enum logic [1:0] {
    CARREGA_A = 2'b00,
    CARREGA_B = 2'b01,
    OPERA     = 2'b10,
    MOSTRA    = 2'b11
  } estado_t;

  localparam logic [2:0] HAB_A    = 3'b001;
  localparam logic [2:0] HAB_B    = 3'b010;
  localparam logic [2:0] HAB_OP   = 3'b100;
  localparam logic [2:0] HAB_NONE = 3'b000;

  localparam logic OP_SOMA = 1'b0;
  localparam logic OP_MULT = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments, bit6..0 = g..a
  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sistema_opera.sv
// Arithmetic unit: single-cycle add or 4-cycle shift-add multiply (LSB of b
// first) while start is held; owns the result register.
module sistema_opera
  import sistema_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       done,
  output logic [7:0] result
);

  logic [1:0] cnt;
  logic [7:0] acc;
  logic [7:0] partial;
  logic [7:0] sum;

  always_comb begin
    partial = acc + (b[cnt] ? ({4'b0000, a} << cnt) : 8'h00);
    sum     = {3'b000, {1'b0, a} + {1'b0, b}};
    done    = start && ((op == OP_SOMA) || (cnt == 2'd3));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 2'd0;
      acc    <= 8'h00;
      result <= 8'h00;
    end else if (start) begin
      if (op == OP_SOMA) begin
        result <= sum;
      end else if (cnt == 2'd3) begin
        result <= partial;
        cnt    <= 2'd0;
        acc    <= 8'h00;
      end else begin
        acc <= partial;
        cnt <= cnt + 2'd1;
      end
    end else begin
      // Idle: keep the multiplier ready to start from bit 0.
      cnt <= 2'd0;
      acc <= 8'h00;
    end
  end

endmodule

// File: rtl/sistema_calc.sv
// Top level: control FSM, operand registers, show counter and hex displays.
// Define SISTEMA_BLANK_EN to blank both digits outside the MOSTRA state.
module sistema_calc
  import sistema_pkg::*;
#(
  parameter int SHOW_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Funcao,
  output logic [6:0] Hex1,
  output logic [6:0] Hex0,
  output logic [2:0] habilita,
  output logic [1:0] estado,
  output logic       sFimA,
  output logic       sFimB,
  output logic       sFimOp
);

  localparam int CNT_W = $clog2(SHOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);

  estado_t          estado_q, estado_n;
  logic [3:0]       reg_a, reg_b;
  logic             op;
  logic [CNT_W-1:0] show_cnt;
  logic             op_done;
  logic [7:0]       result;

  assign estado = estado_q;

  sistema_opera u_opera (
    .clk    (clk),
    .rst    (rst),
    .start  (estado_q == OPERA),
    .op     (op),
    .a      (reg_a),
    .b      (reg_b),
    .done   (op_done),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (rst) estado_q <= CARREGA_A;
    else     estado_q <= estado_n;
  end

  always_comb begin
    estado_n = estado_q;
    habilita = HAB_NONE;
    case (estado_q)
      CARREGA_A: begin
        habilita = HAB_A;
        estado_n = CARREGA_B;
      end
      CARREGA_B: begin
        habilita = HAB_B;
        estado_n = OPERA;
      end
      OPERA: begin
        habilita = HAB_OP;
        if (op_done) estado_n = MOSTRA;
      end
      default: begin
        if (show_cnt == SHOW_LAST) estado_n = CARREGA_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a    <= 4'h0;
      reg_b    <= 4'h0;
      op       <= OP_SOMA;
      sFimA    <= 1'b0;
      sFimB    <= 1'b0;
      sFimOp   <= 1'b0;
      show_cnt <= '0;
    end else begin
      case (estado_q)
        CARREGA_A: begin
          reg_a  <= A;
          sFimA  <= 1'b1;
          sFimB  <= 1'b0;
          sFimOp <= 1'b0;
        end
        CARREGA_B: begin
          reg_b <= B;
          op    <= Funcao;
          sFimB <= 1'b1;
        end
        OPERA: begin
          if (op_done) sFimOp <= 1'b1;
        end
        default: begin
          show_cnt <= (show_cnt == SHOW_LAST) ? '0 : show_cnt + CNT_W'(1);
        end
      endcase
    end
  end

`ifdef SISTEMA_BLANK_EN
  assign Hex1 = (estado_q == MOSTRA) ? hex7seg(result[7:4]) : SEG_BLANK;
  assign Hex0 = (estado_q == MOSTRA) ? hex7seg(result[3:0]) : SEG_BLANK;
`else
  assign Hex1 = hex7seg(result[7:4]);
  assign Hex0 = hex7seg(result[3:0]);
`endif

endmodule

// File: tb/tb_sistema_calc.sv
// Scoreboard bench for sistema_calc: stimulus pushes expected digit patterns,
// a monitor pops and checks them when sFimOp rises.
module tb_sistema_calc;

  localparam int SHOW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] A = 4'h0;
  logic [3:0] B = 4'h0;
  logic       Funcao = 1'b0;
  logic [6:0] Hex1, Hex0;
  logic [2:0] habilita;
  logic [1:0] estado;
  logic       sFimA, sFimB, sFimOp;

  sistema_calc #(.SHOW_CYCLES(SHOW)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Funcao(Funcao),
    .Hex1(Hex1), .Hex0(Hex0), .habilita(habilita), .estado(estado),
    .sFimA(sFimA), .sFimB(sFimB), .sFimOp(sFimOp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] h1;
    logic [6:0] h0;
    int         olen;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [1:0] s);
    int k;
    k = 0;
    while (estado !== s && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (estado !== s) check("wait_state_timeout", {30'd0, estado}, {30'd0, s});
  endtask

  // Vector table: A, B, Funcao, expected Hex1, Hex0
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       f;
    logic [6:0] h1;
    logic [6:0] h0;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'd3,  4'd5,  1'b0, 7'b1000000, 7'b0000000}; // 08
    vecs[1] = '{4'd3,  4'd5,  1'b1, 7'b1000000, 7'b0001110}; // 0F
    vecs[2] = '{4'd15, 4'd15, 1'b1, 7'b0000110, 7'b1111001}; // E1
    vecs[3] = '{4'd15, 4'd15, 1'b0, 7'b1111001, 7'b0000110}; // 1E
    vecs[4] = '{4'd0,  4'd9,  1'b1, 7'b1000000, 7'b1000000}; // 00
    vecs[5] = '{4'd12, 4'd10, 1'b1, 7'b1111000, 7'b0000000}; // 78
    vecs[6] = '{4'd9,  4'd6,  1'b0, 7'b1000000, 7'b0001110}; // 0F
    vecs[7] = '{4'd10, 4'd11, 1'b0, 7'b1111001, 7'b0010010}; // 15
    vecs[8] = '{4'd2,  4'd3,  1'b1, 7'b1000000, 7'b0000010}; // 06
  end

  // Monitor
  initial begin
    logic prev_op;
    int   ocnt, mcnt;
    bit   have;
    exp_t cur;
    prev_op = 1'b0; ocnt = 0; mcnt = 0; have = 0;
    cur = '{7'd0, 7'd0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_op = 1'b0; ocnt = 0; mcnt = 0; have = 0;
      end else begin
        case (estado)
          2'b00:   check("habilita", {29'd0, habilita}, 32'b001);
          2'b01:   check("habilita", {29'd0, habilita}, 32'b010);
          2'b10:   check("habilita", {29'd0, habilita}, 32'b100);
          default: check("habilita", {29'd0, habilita}, 32'b000);
        endcase
        if (estado == 2'b10) ocnt++;
        if (estado == 2'b11) mcnt++;
        if (sFimOp && !prev_op) begin
          if (sbq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_result: got Hex1=%b Hex0=%b, expected none", Hex1, Hex0);
          end else begin
            cur  = sbq.pop_front();
            have = 1;
            check("hex1", {25'd0, Hex1}, {25'd0, cur.h1});
            check("hex0", {25'd0, Hex0}, {25'd0, cur.h0});
            check("opera_len", ocnt, cur.olen);
            check("estado_at_done", {30'd0, estado}, 32'd3);
            check("flags_at_done", {30'd0, sFimA, sFimB}, 32'b11);
          end
        end
        if (estado == 2'b11 && have) begin
          check("hex1_hold", {25'd0, Hex1}, {25'd0, cur.h1});
          check("hex0_hold", {25'd0, Hex0}, {25'd0, cur.h0});
        end
        if (estado == 2'b00) begin
          if (mcnt != 0) check("mostra_len", mcnt, SHOW);
          mcnt = 0;
          ocnt = 0;
        end
        prev_op = sFimOp;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    wait_state(2'b00);
    A = v.a; B = v.b; Funcao = v.f;
    e.h1 = v.h1; e.h0 = v.h0; e.olen = v.f ? 4 : 1;
    sbq.push_back(e);
    @(negedge clk);
    check("estado_b", {30'd0, estado}, 32'd1);
    check("flags_b", {29'd0, sFimA, sFimB, sFimOp}, 32'b100);
    @(negedge clk);
    check("estado_op", {30'd0, estado}, 32'd2);
    check("flags_op", {30'd0, sFimA, sFimB}, 32'b11);
    // Scramble inputs after capture; must not affect this round.
    A = ~v.a; B = v.b + 4'd7; Funcao = ~v.f;
    wait_state(2'b11);
    A = v.a + 4'd1; B = ~v.b; Funcao = v.f;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_estado", {30'd0, estado}, 32'd0);
    check("rst_habilita", {29'd0, habilita}, 32'b001);
    check("rst_flags", {29'd0, sFimA, sFimB, sFimOp}, 32'd0);
`ifdef SISTEMA_BLANK_EN
    check("rst_hex", {18'd0, Hex1, Hex0}, {18'd0, 7'b1111111, 7'b1111111});
`else
    check("rst_hex", {18'd0, Hex1, Hex0}, {18'd0, 7'b1000000, 7'b1000000});
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset during the second multiply cycle discards the partial product.
    wait_state(2'b00);
    A = 4'd7; B = 4'd9; Funcao = 1'b1;
    wait_state(2'b10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_estado", {30'd0, estado}, 32'd0);
    check("midrst_flags", {29'd0, sFimA, sFimB, sFimOp}, 32'd0);
`ifdef SISTEMA_BLANK_EN
    check("midrst_hex", {18'd0, Hex1, Hex0}, {18'd0, 7'b1111111, 7'b1111111});
`else
    check("midrst_hex", {18'd0, Hex1, Hex0}, {18'd0, 7'b1000000, 7'b1000000});
`endif
    rst = 1'b0;

    run_vec(vecs[8]);

    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", sbq.size(), 0);
    wait_state(2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
